// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter: round-robin sharing of one single-port command RAM between two requesters.
// ADDR_SIZE must equal MEM_WIDTH since address and data share the low bits of ram_din.
module ram_req_arbiter #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_wr,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [2*MEM_WIDTH-1:0] req_wdata,
    output logic [1:0]             resp_valid,
    output logic                   resp_err,
    output logic [MEM_WIDTH-1:0]   resp_rdata,
    output logic                   busy,
    output logic [MEM_WIDTH+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [MEM_WIDTH-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD1 = 3'd1;
    localparam logic [2:0] CMD2 = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] RESP = 3'd4;
    logic [2:0]           state;
    logic                 g_q, wr_q, last_grant, err_q;
    logic [ADDR_SIZE-1:0] addr_q, sel_addr;
    logic [MEM_WIDTH-1:0] wdata_q, rdata_q, sel_wdata;
    logic [3:0]           cnt;
    logic                 grant, accept;
    always_comb begin
        grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        req_ready  = (state == IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
        accept     = |req_ready;
        sel_addr   = grant ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
        sel_wdata  = grant ? req_wdata[2*MEM_WIDTH-1:MEM_WIDTH] : req_wdata[MEM_WIDTH-1:0];
        resp_valid = (state == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
        resp_err   = (state == RESP) && err_q;
        resp_rdata = (state == RESP) ? rdata_q : '0;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            g_q          <= 1'b0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt          <= '0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state        <= CMD1;
                    g_q          <= grant;
                    last_grant   <= grant;
                    wr_q         <= req_wr[grant];
                    addr_q       <= sel_addr;
                    wdata_q      <= sel_wdata;
                    rdata_q      <= '0;
                    err_q        <= 1'b0;
                    ram_rx_valid <= 1'b1;
                    ram_din      <= {(req_wr[grant] ? 2'b00 : 2'b10), sel_addr};
                end
                CMD1: begin
                    state        <= CMD2;
                    ram_rx_valid <= 1'b1;
                    ram_din      <= wr_q ? {2'b01, wdata_q} : {2'b11, {MEM_WIDTH{1'b0}}};
                end
                CMD2: begin
                    state <= wr_q ? RESP : WAIT;
                    cnt   <= 4'd1;
                end
                // RAM answers one cycle after the {11} command; give up after TIMEOUT cycles
                WAIT: if (ram_tx_valid) begin
                    rdata_q <= ram_dout;
                    state   <= RESP;
                end else if (cnt == 4'(TIMEOUT)) begin
                    err_q <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter: directed table, corner sequences and randomized round-robin checks.
module tb_ram_req_arbiter;
    localparam int TIMEOUT = 4;
    logic        clk = 0, rst = 1;
    logic [1:0]  req_valid = 0, req_ready, req_wr = 0, resp_valid;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        resp_err, busy, ram_rx_valid, ram_tx_valid;
    logic [7:0]  resp_rdata, ram_dout;
    logic [9:0]  ram_din;
    int          n_cmp = 0, n_fail = 0, cyc = 0;
    ram_req_arbiter #(.MEM_WIDTH(8), .ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Behavioural command RAM: tx_valid is a one-cycle pulse after a {11} command
    logic [7:0] mem [256];
    logic [7:0] wa = 0, ra = 0;
    logic       txv = 0, tx_kill = 0;
    initial for (int i = 0; i < 256; i++) mem[i] = 0;
    always @(posedge clk) begin
        txv <= 1'b0;
        if (ram_rx_valid)
            case (ram_din[9:8])
                2'b00: wa <= ram_din[7:0];
                2'b01: mem[wa] <= ram_din[7:0];
                2'b10: ra <= ram_din[7:0];
                default: begin ram_dout <= mem[ra]; txv <= 1'b1; end
            endcase
    end
    assign ram_tx_valid = txv & ~tx_kill;
    // Reference model state
    logic [7:0] ref_mem [256];
    bit         pend [2];
    bit         pw [2];
    logic [7:0] pa [2], pd [2];
    int         last = 1;
    typedef struct { int who; bit wr; logic [7:0] a; logic [7:0] d; bit kill; logic [7:0] rd; bit err; } vec_t;
    vec_t tbl [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic int pick();
        return (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
    endfunction
    task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
        pend[i] = 1; pw[i] = wr; pa[i] = a; pd[i] = d;
        req_valid[i] = 1'b1; req_wr[i] = wr;
        req_addr[i*8 +: 8] = a; req_wdata[i*8 +: 8] = d;
    endtask
    task automatic do_reset();
        rst = 1; req_valid = 0; tx_kill = 0;
        repeat (2) @(negedge clk);
        rst = 0; last = 1; pend[0] = 0; pend[1] = 0;
    endtask
    task automatic serve(input int g, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit exp_err, output int acc);
        int n = 0, lat;
        #1;
        while ((req_valid & req_ready) == 0 && n < 40) begin @(negedge clk); n++; end
        acc = cyc;
        chk("grant", req_valid & req_ready, (g == 0) ? 2'b01 : 2'b10);
        if (n >= 40) return;
        last = g; pend[g] = 0;
        @(negedge clk);
        req_valid[g] = 0; req_wr[g] = 1'($urandom);
        req_addr[g*8 +: 8] = 8'($urandom); req_wdata[g*8 +: 8] = 8'($urandom);
        chk("cmd1_rx", ram_rx_valid, 1);
        chk("cmd1_din", ram_din, {(wr ? 2'b00 : 2'b10), a});
        chk("busy", busy, 1);
        @(negedge clk);
        chk("cmd2_rx", ram_rx_valid, 1);
        chk("cmd2_din", ram_din, wr ? {2'b01, d} : 10'h300);
        if (wr) ref_mem[a] = d;
        lat = wr ? 3 : (tx_kill ? 3 + TIMEOUT : 4);
        for (int c = 3; c < lat; c++) begin
            @(negedge clk);
            chk("resp_early", resp_valid, 0);
        end
        @(negedge clk);
        chk("resp_valid", resp_valid, (g == 0) ? 2'b01 : 2'b10);
        chk("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_rx_idle", ram_rx_valid, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask
    initial begin
        int acc, prev, g, k;
        bit kill;
        logic [7:0] bd [3], exp;
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
        tbl[0] = '{0, 1, 8'h3C, 8'hA5, 0, 8'h00, 0};
        tbl[1] = '{1, 0, 8'h3C, 8'h00, 0, 8'hA5, 0};
        tbl[2] = '{0, 0, 8'h3C, 8'h00, 1, 8'h00, 1};
        tbl[3] = '{1, 1, 8'h81, 8'h5A, 0, 8'h00, 0};
        tbl[4] = '{0, 0, 8'h81, 8'h00, 0, 8'h5A, 0};
        tbl[5] = '{1, 0, 8'h3C, 8'h00, 0, 8'hA5, 0};
        do_reset();
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rx_valid", ram_rx_valid, 0);
        // Contention from reset: both held valid, grants must alternate starting at 0
        set_req(0, 1, 8'h10, 8'($urandom));
        set_req(1, 1, 8'h20, 8'($urandom));
        for (k = 0; k < 4; k++) begin
            g = pick();
            serve(g, pw[g], pa[g], pd[g], 8'h00, 0, acc);
            set_req(g, 1, 8'(8'h10 + 16 * g + k + 1), 8'($urandom));
        end
        req_valid = 0; pend[0] = 0; pend[1] = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            set_req(tbl[i].who, tbl[i].wr, tbl[i].a, tbl[i].d);
            tx_kill = tbl[i].kill;
            serve(tbl[i].who, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].err, acc);
            tx_kill = 0;
        end
        // Reset during CMD2 of a read aborts without a response
        set_req(0, 0, 8'h3C, 8'h00);
        #1;
        k = 0;
        while ((req_valid & req_ready) == 0 && k < 40) begin @(negedge clk); k++; end
        chk("abort_grant", req_valid & req_ready, 2'b01);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; last = 1; pend[0] = 0;
        chk("abort_rx", ram_rx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_resp", resp_valid, 0);
        repeat (3) begin @(negedge clk); chk("abort_no_resp", resp_valid, 0); end
        set_req(0, 0, 8'h3C, 8'h00);
        serve(0, 0, 8'h3C, 8'h00, ref_mem[8'h3C], 0, acc);
        // Back-to-back: 3 writes then 3 reads, accepted every 4/5 cycles
        prev = 0;
        for (k = 0; k < 6; k++) begin
            if (k < 3) bd[k] = 8'($urandom);
            set_req(0, k < 3, 8'(8'h50 + k % 3), (k < 3) ? bd[k] : 8'h00);
            serve(0, k < 3, 8'(8'h50 + k % 3), (k < 3) ? bd[k] : 8'h00, (k < 3) ? 8'h00 : bd[k % 3], 0, acc);
            if (k > 0) chk("b2b_gap", acc - prev, (k <= 3) ? 4 : 5);
            prev = acc;
        end
        // Randomized traffic against the reference model
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1)
                    set_req(i, 1'($urandom), 8'($urandom_range(8'h67, 8'h60)), 8'($urandom));
            if (!pend[0] && !pend[1])
                set_req(int'($urandom_range(1, 0)), 1'($urandom), 8'($urandom_range(8'h67, 8'h60)), 8'($urandom));
            g = pick();
            kill = !pw[g] && $urandom_range(4, 0) == 0;
            tx_kill = kill;
            exp = kill ? 8'h00 : ref_mem[pa[g]];
            serve(g, pw[g], pa[g], pd[g], pw[g] ? 8'h00 : exp, kill, acc);
            tx_kill = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
